y_conv_core: RTL and testbench



---
 rtl/y_conv_pkg.sv | 38 +++
 rtl/y_conv_row_mac.sv | 19 +
 rtl/y_conv_core.sv | 113 +++++++++++
 tb/tb_y_conv_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/y_conv_pkg.sv
// Shared types, limits and magnitude reduction for the Y-gradient convolution engine.
// Define Y_CONV_SAT_EN to clamp oversize magnitudes to CONV_MAX instead of wrapping them.
package y_conv_pkg;

    typedef logic [3:0]        pixel_t;
    typedef logic signed [4:0] coef_t;

    typedef pixel_t [2:0]      pix_row_t;
    typedef coef_t  [2:0]      coef_row_t;
    typedef pix_row_t  [2:0]   window_t;
    typedef coef_row_t [2:0]   kernel_t;

    typedef logic signed [12:0] acc_t;
    typedef logic signed [10:0] row_sum_t;
    typedef logic [9:0]         conv_t;

    localparam conv_t CONV_MAX = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW0,
        ST_ROW1,
        ST_ROW2,
        ST_DONE
    } state_t;

    // |s| fits in 13 bits because the accumulator never reaches -4096.
    function automatic conv_t reduce_mag(input acc_t s);
        acc_t mag;
        mag = s[12] ? -s : s;
`ifdef Y_CONV_SAT_EN
        return (mag > acc_t'(CONV_MAX)) ? CONV_MAX : mag[9:0];
`else
        return mag[9:0];
`endif
    endfunction

endpackage

// File: rtl/y_conv_row_mac.sv
// Combinational 3-tap dot product of one unsigned pixel row with one signed coefficient row.
module y_conv_row_mac
    import y_conv_pkg::*;
(
    input  pix_row_t  pix_row,
    input  coef_row_t coef_row,
    output row_sum_t  row_sum
);

    row_sum_t prod [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
        assign prod[gi] = $signed({7'b0, pix_row[gi]}) *
                          $signed({{6{coef_row[gi][4]}}, coef_row[gi]});
    end

    assign row_sum = prod[0] + prod[1] + prod[2];

endmodule

// File: rtl/y_conv_core.sv
// Sequential 3x3 Y-gradient convolution: one row per cycle, |sum| published two cycles after the last row.
// Saturating or wrapping output is selected by the Y_CONV_SAT_EN macro (see y_conv_pkg).
module y_conv_core
    import y_conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  calc_enable,
    input  logic [2:0][2:0][3:0]  pixels,
    input  logic [2:0][2:0][4:0]  filter,
    output logic                  calc_done,
    output logic [9:0]            conv
);

    state_t   state_q, state_d;
    window_t  pix_q, pix_d;
    kernel_t  coef_q, coef_d;
    acc_t     acc_q, acc_d;
    conv_t    res_q, res_d;
    conv_t    conv_q, conv_d;
    logic     done_q, done_d;

    logic     [1:0] row_sel;
    row_sum_t row_sum;
    acc_t     acc_sum;
    logic     accept;

    always_comb begin
        row_sel = 2'd0;
        case (state_q)
            ST_ROW1: row_sel = 2'd1;
            ST_ROW2: row_sel = 2'd2;
            default: row_sel = 2'd0;
        endcase
    end

    y_conv_row_mac u_row_mac (
        .pix_row  (pix_q[row_sel]),
        .coef_row (coef_q[row_sel]),
        .row_sum  (row_sum)
    );

    assign acc_sum = acc_q + acc_t'(row_sum);

    // A restart from DONE is only honoured once the previous result has been published.
    assign accept = calc_enable && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && done_q));

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        res_d   = res_q;
        conv_d  = conv_q;
        done_d  = done_q;

        case (state_q)
            ST_ROW0: begin
                acc_d   = acc_sum;
                state_d = ST_ROW1;
            end
            ST_ROW1: begin
                acc_d   = acc_sum;
                state_d = ST_ROW2;
            end
            ST_ROW2: begin
                acc_d   = acc_sum;
                res_d   = reduce_mag(acc_sum);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!done_q) begin
                    conv_d = res_q;
                    done_d = 1'b1;
                end
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            pix_d   = pixels;
            coef_d  = filter;
            acc_d   = '0;
            done_d  = 1'b0;
            state_d = ST_ROW0;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= ST_IDLE;
            pix_q   <= '0;
            coef_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            conv_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            conv_q  <= conv_d;
            done_q  <= done_d;
        end
    end

    assign calc_done = done_q;
    assign conv      = conv_q;

endmodule

// File: tb/tb_y_conv_core.sv
// Randomized scoreboard bench for y_conv_core; expected magnitudes come from a plain-arithmetic model.
module tb_y_conv_core;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b1;
    logic                 calc_enable = 1'b0;
    logic [2:0][2:0][3:0] pixels = '0;
    logic [2:0][2:0][4:0] filter = '0;
    logic                 calc_done;
    logic [9:0]           conv;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int txn    = 0;
    int exp_q[$];
    int cyc_q[$];
    int last_conv = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    y_conv_core dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .calc_enable (calc_enable),
        .pixels      (pixels),
        .filter      (filter),
        .calc_done   (calc_done),
        .conv        (conv)
    );

    // Reference: direct sum of products, then magnitude and the configured 10-bit reduction.
    function automatic int model(input logic [2:0][2:0][3:0] p, input logic [2:0][2:0][4:0] k);
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += int'(p[r][c]) * int'($signed(k[r][c]));
        if (s < 0) s = -s;
`ifdef Y_CONV_SAT_EN
        return (s > 1023) ? 1023 : s;
`else
        return s % 1024;
`endif
    endfunction

    function automatic logic [2:0][2:0][4:0] kern(input int v[9]);
        logic [2:0][2:0][4:0] k;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                k[r][c] = 5'(v[r*3+c]);
        return k;
    endfunction

    function automatic logic [2:0][2:0][3:0] win(input int v[9]);
        logic [2:0][2:0][3:0] p;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = 4'(v[r*3+c]);
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue a one-cycle start, then scramble the inputs to prove the captured copies are used.
    task automatic start_txn(input logic [2:0][2:0][3:0] p, input logic [2:0][2:0][4:0] k);
        @(negedge clk);
        pixels = p;
        filter = k;
        calc_enable = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(p, k));
        cyc_q.push_back(cyc);
        calc_enable = 1'b0;
        pixels = 36'({$urandom(), $urandom()});
        filter = 45'({$urandom(), $urandom()});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    always @(negedge clk or posedge n_rst) begin
        if (n_rst) begin
            exp_q.delete();
            cyc_q.delete();
            last_conv = 0;
            done_prev = 1'b0;
        end else begin
            if (calc_done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    int e, ec;
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    txn++;
                    $display("txn %0d: conv=%0d expected=%0d latency=%0d", txn, conv, e, cyc - ec);
                    chk("conv", int'(conv), e);
                    chk("latency", cyc - ec, 4);
                    last_conv = int'(conv);
                end
            end else if (exp_q.size() > 0 && cyc > cyc_q[0] && cyc < cyc_q[0] + 4) begin
                chk("busy_done", int'(calc_done), 0);
                chk("conv_hold", int'(conv), last_conv);
            end
            done_prev = calc_done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[9];
        int k[9];

        #2;
        chk("rst_conv", int'(conv), 0);
        chk("rst_done", int'(calc_done), 0);
        @(negedge clk);
        n_rst = 1'b0;

        repeat (4) begin
            @(posedge clk);
            #1;
            chk("idle_conv", int'(conv), 0);
            chk("idle_done", int'(calc_done), 0);
        end

        // calc_enable held over three edges: only the first is accepted, nothing visible yet.
        v = '{3, 7, 1, 0, 15, 2, 9, 4, 6};
        k = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        @(negedge clk);
        pixels = win(v);
        filter = kern(k);
        calc_enable = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(win(v), kern(k)));
        cyc_q.push_back(cyc);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("hold_conv", int'(conv), 0);
        chk("hold_done", int'(calc_done), 0);
        @(negedge clk);
        calc_enable = 1'b0;
        wait_drain();

        v = '{15, 15, 15, 0, 0, 0, 0, 0, 0};
        start_txn(win(v), kern(k));
        wait_drain();

        k = '{1, 8, 1, 0, 0, 0, -1, -8, -1};
        v = '{0, 0, 0, 0, 0, 0, 15, 15, 15};
        start_txn(win(v), kern(k));
        wait_drain();
        v = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
        start_txn(win(v), kern(k));
        wait_drain();

        k = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        v = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        start_txn(win(v), kern(k));
        wait_drain();
        k = '{-16, -16, -16, -16, -16, -16, -16, -16, -16};
        start_txn(win(v), kern(k));
        wait_drain();

        // Reset two edges into a computation discards it; a fresh start must still work.
        k = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        v = '{9, 9, 9, 1, 2, 3, 0, 0, 0};
        start_txn(win(v), kern(k));
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        chk("midrst_conv", int'(conv), 0);
        chk("midrst_done", int'(calc_done), 0);
        #1;
        n_rst = 1'b0;
        start_txn(win(v), kern(k));
        wait_drain();

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 9; i++) begin
                v[i] = int'($urandom_range(15));
                k[i] = int'($urandom_range(31)) - 16;
            end
            repeat ($urandom_range(2)) @(negedge clk);
            start_txn(win(v), kern(k));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
